// File: rtl/binary_mul_seq.sv
// Iterative shift-add multiplier: retires RADIX_BITS multiplier bits per enabled cycle,
// signed or unsigned per operation, with a start/busy/done handshake.
`timescale 1ns/1ps
module binary_mul_seq #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int unsigned Iter    = (WIDTH + RADIX_BITS - 1) / RADIX_BITS;
    localparam int unsigned MagBW   = Iter * RADIX_BITS;
    localparam int unsigned ProdW   = 2 * WIDTH;
    localparam int unsigned CntW    = (Iter > 1) ? $clog2(Iter) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Iter - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [ProdW-1:0]  a_sh_q;
    logic [MagBW-1:0]  b_rem_q;
    logic [ProdW-1:0]  acc_q;
    logic              neg_q;
    logic              busy_q;
    logic              done_q;
    logic [ProdW-1:0]  p_q;

    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [ProdW-1:0]  a_ext;
    logic [MagBW-1:0]  b_ext;
    logic [ProdW-1:0]  pp;
    logic [ProdW-1:0]  acc_d;
    logic [ProdW-1:0]  prod_d;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits WIDTH bits unsigned.
    always_comb begin
        a_neg = is_signed & A[WIDTH-1];
        b_neg = is_signed & B[WIDTH-1];
        a_mag = a_neg ? (~A + WIDTH'(1)) : A;
        b_mag = b_neg ? (~B + WIDTH'(1)) : B;
        a_ext = '0;
        a_ext[WIDTH-1:0] = a_mag;
        b_ext = '0;
        b_ext[WIDTH-1:0] = b_mag;
    end

    // Partial product of the current low RADIX_BITS of |B| with the pre-shifted |A|.
    always_comb begin
        pp = '0;
        for (int i = 0; i < int'(RADIX_BITS); i++) begin
            if (b_rem_q[i]) begin
                pp = pp + (a_sh_q << i);
            end
        end
        acc_d  = acc_q + pp;
        prod_d = neg_q ? (~acc_d + ProdW'(1)) : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_rem_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else if (en) begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                state_q <= StRun;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                a_sh_q  <= a_ext;
                b_rem_q <= b_ext;
                acc_q   <= '0;
                neg_q   <= a_neg ^ b_neg;
            end else begin
                unique case (state_q)
                    StRun: begin
                        a_sh_q  <= a_sh_q << RADIX_BITS;
                        b_rem_q <= b_rem_q >> RADIX_BITS;
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            p_q     <= prod_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule

// File: tb/tb_binary_mul_seq.sv
// Bench for binary_mul_seq: three WIDTH=6 builds (radix 1/2/3) share stimulus and are checked
// against an integer-arithmetic reference for product, latency and handshake behaviour.
`timescale 1ns/1ps
module tb_binary_mul_seq;

    localparam int W  = 6;
    localparam int PW = 12;
    localparam int Lat [3] = '{6, 3, 2};

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 start;
    logic                 is_signed;
    logic [W-1:0]         a_in;
    logic [W-1:0]         b_in;
    logic [2:0]           busy_v;
    logic [2:0]           done_v;
    logic [2:0][PW-1:0]   p_v;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        logic [PW-1:0] p;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    binary_mul_seq #(.WIDTH(W), .RADIX_BITS(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .is_signed(is_signed),
        .A(a_in), .B(b_in), .busy(busy_v[0]), .done(done_v[0]), .P(p_v[0])
    );
    binary_mul_seq #(.WIDTH(W), .RADIX_BITS(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .is_signed(is_signed),
        .A(a_in), .B(b_in), .busy(busy_v[1]), .done(done_v[1]), .P(p_v[1])
    );
    binary_mul_seq #(.WIDTH(W), .RADIX_BITS(3)) u_r3 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .is_signed(is_signed),
        .A(a_in), .B(b_in), .busy(busy_v[2]), .done(done_v[2]), .P(p_v[2])
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut r%0d): got %0h expected %0h at %0t", name, idx + 1, act, exp,
                     $time);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        int x;
        int y;
        int prod;
        if (s) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        prod = x * y;
        return PW'(prod);
    endfunction

    // Starts at a negedge, returns at the negedge where the radix-1 build shows done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [PW-1:0] exp, input bit rand_en);
        int k;
        int cyc;
        bit fin;
        en        = 1'b1;
        start     = 1'b1;
        a_in      = a;
        b_in      = b;
        is_signed = s;
        @(negedge clk);
        start     = 1'b0;
        a_in      = W'($urandom);
        b_in      = W'($urandom);
        is_signed = 1'($urandom);
        k   = 0;
        cyc = 0;
        fin = 1'b0;
        while (!fin) begin
            for (int i = 0; i < 3; i++) begin
                check("done", i, 32'(done_v[i]), 32'(k == Lat[i]));
                check("busy", i, 32'(busy_v[i]), 32'(k < Lat[i]));
                if (k == Lat[i]) check("product", i, 32'(p_v[i]), 32'(exp));
            end
            if (k >= Lat[0]) begin
                fin = 1'b1;
            end else begin
                en = (rand_en && cyc < 20) ? ($urandom_range(3) != 0) : 1'b1;
                @(negedge clk);
                if (en) k++;
                cyc++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{a: 6'd63, b: 6'd63, s: 1'b0, p: 12'hF81};
        vecs[1] = '{a: 6'h20, b: 6'h20, s: 1'b1, p: 12'h400};
        vecs[2] = '{a: 6'h3F, b: 6'h01, s: 1'b1, p: 12'hFFF};
        vecs[3] = '{a: 6'h3B, b: 6'h07, s: 1'b1, p: 12'hFDD};
        vecs[4] = '{a: 6'h00, b: 6'h20, s: 1'b1, p: 12'h000};
        vecs[5] = '{a: 6'd10, b: 6'd12, s: 1'b0, p: 12'd120};
        vecs[6] = '{a: 6'h20, b: 6'h3F, s: 1'b0, p: 12'h7E0};
        vecs[7] = '{a: 6'h1F, b: 6'h20, s: 1'b1, p: 12'hC20};
        vecs[8] = '{a: 6'h20, b: 6'h01, s: 1'b1, p: 12'hFE0};

        rst_n = 1'b0; en = 1'b0; start = 1'b0; is_signed = 1'b0; a_in = '0; b_in = '0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check("reset busy", i, 32'(busy_v[i]), 32'd0);
            check("reset done", i, 32'(done_v[i]), 32'd0);
            check("reset P", i, 32'(p_v[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) run_op(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].p, 1'b0);

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 64; a++)
                for (int b = 0; b < 64; b++)
                    run_op(W'(a), W'(b), 1'(s), ref_mul(W'(a), W'(b), 1'(s)), 1'b0);

        for (int r = 0; r < 300; r++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, ref_mul(ra, rb, rs), 1'b1);
        end

        // Start while busy is ignored; start in the done cycle is accepted (radix-1 build).
        repeat (8) @(negedge clk);
        en = 1'b1; start = 1'b1; a_in = 6'd63; b_in = 6'd63; is_signed = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            start = (k == 2 || k == 4);
            a_in  = 6'd5;
            b_in  = 6'd9;
            @(negedge clk);
            check("ignored start done", 0, 32'(done_v[0]), 32'(k == 6));
            check("ignored start busy", 0, 32'(busy_v[0]), 32'(k != 6));
        end
        check("ignored start P", 0, 32'(p_v[0]), 32'h0F81);
        start = 1'b1; a_in = 6'd10; b_in = 6'd12; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("b2b accept busy", 0, 32'(busy_v[0]), 32'd1);
        check("b2b accept done", 0, 32'(done_v[0]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("b2b done", 0, 32'(done_v[0]), 32'(k == 6));
            check("b2b P", 0, 32'(p_v[0]), (k == 6) ? 32'd120 : 32'h0F81);
        end

        // Enable drops: five cycles mid-operation, then three while done is high.
        repeat (8) @(negedge clk);
        en = 1'b1; start = 1'b1; a_in = 6'h3B; b_in = 6'd7; is_signed = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            en = !(c >= 3 && c <= 7);
            @(negedge clk);
            check("en freeze done", 0, 32'(done_v[0]), 32'(c == 11));
            if (c < 11) begin
                check("en freeze busy", 0, 32'(busy_v[0]), 32'd1);
                check("en freeze P", 0, 32'(p_v[0]), 32'd120);
            end
        end
        check("en freeze result", 0, 32'(p_v[0]), 32'h0FDD);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stretched done", 0, 32'(done_v[0]), 32'd1);
            check("stretched P", 0, 32'(p_v[0]), 32'h0FDD);
        end
        en = 1'b1;
        @(negedge clk);
        check("done after stretch", 0, 32'(done_v[0]), 32'd0);
        check("busy after stretch", 0, 32'(busy_v[0]), 32'd0);

        // Asynchronous reset between edges mid-operation.
        repeat (8) @(negedge clk);
        start = 1'b1; a_in = 6'd63; b_in = 6'd63; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset done r3", 2, 32'(done_v[2]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("async reset busy", i, 32'(busy_v[i]), 32'd0);
            check("async reset done", i, 32'(done_v[i]), 32'd0);
            check("async reset P", i, 32'(p_v[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(6'd10, 6'd12, 1'b0, 12'd120, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
